// File: rtl/abm_set_notifier_pkg.sv
// Shared definitions for the ABM set notifier.
//   DEF_CNT_W / DEF_TO_W : default counter and timer widths
//   ch_lsb()             : LSB position of channel i inside the flat ch_count bus
package abm_set_notifier_pkg;

   localparam int DEF_CNT_W = 32;
   localparam int DEF_TO_W  = 32;

   // Channel i occupies ch_count[ch_lsb(i, w) +: w].
   function automatic int ch_lsb(input int ch, input int cnt_w);
      return ch * cnt_w;
   endfunction

endpackage

// File: rtl/abm_chan_tracker.sv
// Per-channel state of the ABM set notifier.
//   clk, resetn  : clock, synchronous active-low reset
//   upd          : 1-cycle "ABM updated" strobe for this channel
//   set_done     : the set completes on this edge (pending bit clears)
//   drop         : partial set discarded on timeout; this cycle's strobe starts the new set
//   clear_err    : clears the sticky overrun flag
//   pending      : channel has contributed to the current set
//   ovr_hit      : combinational, channel updated again while already pending
//   ch_count     : free-running update counter (wraps)
//   ovr_sticky   : sticky overrun flag
module abm_chan_tracker
   import abm_set_notifier_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             upd,
   input  logic             set_done,
   input  logic             drop,
   input  logic             clear_err,
   output logic             pending,
   output logic             ovr_hit,
   output logic [CNT_W-1:0] ch_count,
   output logic             ovr_sticky
);

   assign ovr_hit = upd & pending;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pending    <= 1'b0;
         ch_count   <= '0;
         ovr_sticky <= 1'b0;
      end else begin
         // Every strobe is counted, even one that overruns the set.
         if (upd) ch_count <= ch_count + CNT_W'(1);

         if (set_done)  pending <= 1'b0;
         else if (drop) pending <= upd;
         else           pending <= pending | upd;

         // A fresh overrun outranks a simultaneous clear.
         if (ovr_hit)        ovr_sticky <= 1'b1;
         else if (clear_err) ovr_sticky <= 1'b0;
      end
   end

endmodule

// File: rtl/abm_set_notifier.sv
// N-channel ABM update notifier: pulses ready once every channel has updated
// once (any order), counts completed sets, flags overruns and partial-set timeouts.
//   clk, resetn  : clock, synchronous active-low reset
//   updated      : per-channel 1-cycle update strobes
//   clear_err    : clears ovr_sticky / to_sticky
//   ch_count     : per-channel update counters, channel i at [i*CNT_W +: CNT_W]
//   set_count    : completed sets (wraps)
//   pending      : channels already seen in the current set
//   ready        : 1-cycle pulse, set completed on the previous edge
//   overrun      : 1-cycle pulse, a channel updated twice within one set
//   timeout      : 1-cycle pulse, partial set waited TIMEOUT cycles
//   ovr_sticky   : per-channel sticky overrun
//   to_sticky    : sticky timeout
module abm_set_notifier
   import abm_set_notifier_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TO_W       = DEF_TO_W,
   parameter int TIMEOUT    = 0,
   parameter int DROP_ON_TO = 0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       updated,
   input  logic                    clear_err,
   output logic [NUM_CH*CNT_W-1:0] ch_count,
   output logic [CNT_W-1:0]        set_count,
   output logic [NUM_CH-1:0]       pending,
   output logic                    ready,
   output logic                    overrun,
   output logic                    timeout,
   output logic [NUM_CH-1:0]       ovr_sticky,
   output logic                    to_sticky
);

   localparam bit            TO_EN   = (TIMEOUT > 0);
   localparam bit            DROP_EN = (DROP_ON_TO != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] hit;
   logic              complete;
   logic              to_fire;
   logic              drop;
   logic [TO_W-1:0]   timer;

   // A repeated strobe on an already-pending channel adds nothing new, so
   // OR-ing the raw strobes in is the same as OR-ing only the counted ones.
   assign complete = &(pend | updated);
   // Completion outranks timeout; the timer only runs while a set is open.
   assign to_fire  = TO_EN && (|pend) && !complete && (timer == TO_LAST);
   assign drop     = DROP_EN && to_fire;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;

      abm_chan_tracker #(.CNT_W(CNT_W)) u_trk (
         .clk        (clk),
         .resetn     (resetn),
         .upd        (updated[i]),
         .set_done   (complete),
         .drop       (drop),
         .clear_err  (clear_err),
         .pending    (pend[i]),
         .ovr_hit    (hit[i]),
         .ch_count   (cnt),
         .ovr_sticky (ovr_sticky[i])
      );

      assign ch_count[ch_lsb(i, CNT_W) +: CNT_W] = cnt;
   end

   assign pending = pend;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         set_count <= '0;
         timer     <= '0;
         ready     <= 1'b0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
         to_sticky <= 1'b0;
      end else begin
         if (complete) set_count <= set_count + CNT_W'(1);

         if (!TO_EN || complete || !(|pend) || to_fire) timer <= '0;
         else                                           timer <= timer + TO_W'(1);

         ready   <= complete;
         overrun <= |hit;
         timeout <= to_fire;

         if (to_fire)        to_sticky <= 1'b1;
         else if (clear_err) to_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_abm_set_notifier.sv
module tb_abm_set_notifier;

   // DUT A: 4 channels, timeout 10, drop partial set.  DUT B: 3 channels, timeout 5, report only.
   localparam int NA = 4, TA = 10, DA = 1;
   localparam int NB = 3, TB = 5,  DB = 0;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          clear_err = 1'b0;
   logic [NA-1:0] upd_a = '0;
   logic [NB-1:0] upd_b = '0;

   logic [NA*8-1:0] ch_count_a;
   logic [7:0]      set_count_a;
   logic [NA-1:0]   pending_a, ovr_sticky_a;
   logic            ready_a, overrun_a, timeout_a, to_sticky_a;

   logic [NB*8-1:0] ch_count_b;
   logic [7:0]      set_count_b;
   logic [NB-1:0]   pending_b, ovr_sticky_b;
   logic            ready_b, overrun_b, timeout_b, to_sticky_b;

   always #5 clk = ~clk;

   abm_set_notifier #(.NUM_CH(NA), .CNT_W(8), .TO_W(8), .TIMEOUT(TA), .DROP_ON_TO(DA)) dut_a (
      .clk(clk), .resetn(resetn), .updated(upd_a), .clear_err(clear_err),
      .ch_count(ch_count_a), .set_count(set_count_a), .pending(pending_a),
      .ready(ready_a), .overrun(overrun_a), .timeout(timeout_a),
      .ovr_sticky(ovr_sticky_a), .to_sticky(to_sticky_a));

   abm_set_notifier #(.NUM_CH(NB), .CNT_W(8), .TO_W(8), .TIMEOUT(TB), .DROP_ON_TO(DB)) dut_b (
      .clk(clk), .resetn(resetn), .updated(upd_b), .clear_err(clear_err),
      .ch_count(ch_count_b), .set_count(set_count_b), .pending(pending_b),
      .ready(ready_b), .overrun(overrun_b), .timeout(timeout_b),
      .ovr_sticky(ovr_sticky_b), .to_sticky(to_sticky_b));

   // Reference model: state after each clock edge, derived from the set rules.
   typedef struct packed {
      logic [7:0][7:0] cnt;
      logic [7:0]      pend;
      logic [7:0]      setc;
      logic [31:0]     waited;   // cycles the open set has been waiting
      logic            rdy, ovr, to;
      logic [7:0]      ovs;
      logic            tos;
   } mdl_t;

   mdl_t ma, mb;
   int total = 0;
   int bad   = 0;

   function automatic mdl_t step(mdl_t s, int n, int tmo, bit drp,
                                 logic [7:0] u, bit clr, bit rst);
      mdl_t r;
      bit   all_seen, open_set, fire, any_ovr;
      r = s;
      if (rst) return '0;
      all_seen = 1'b1;
      open_set = 1'b0;
      any_ovr  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!(s.pend[i] || u[i])) all_seen = 1'b0;
         if (s.pend[i]) open_set = 1'b1;
         if (s.pend[i] && u[i]) any_ovr = 1'b1;
      end
      fire = (tmo > 0) && open_set && !all_seen && (s.waited == 32'(tmo - 1));
      for (int i = 0; i < n; i++) begin
         if (u[i]) r.cnt[i] = s.cnt[i] + 8'd1;
         if (all_seen)         r.pend[i] = 1'b0;
         else if (fire && drp) r.pend[i] = u[i];
         else                  r.pend[i] = s.pend[i] | u[i];
         if (s.pend[i] && u[i]) r.ovs[i] = 1'b1;
         else if (clr)          r.ovs[i] = 1'b0;
      end
      if (all_seen) r.setc = s.setc + 8'd1;
      r.waited = (open_set && !all_seen && !fire) ? s.waited + 1 : 0;
      r.rdy = all_seen;
      r.ovr = any_ovr;
      r.to  = fire;
      if (fire)     r.tos = 1'b1;
      else if (clr) r.tos = 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a.ch_count",   64'(ch_count_a),   64'(ma.cnt[NA-1:0]));
      chk("a.set_count",  64'(set_count_a),  64'(ma.setc));
      chk("a.pending",    64'(pending_a),    64'(ma.pend[NA-1:0]));
      chk("a.ready",      64'(ready_a),      64'(ma.rdy));
      chk("a.overrun",    64'(overrun_a),    64'(ma.ovr));
      chk("a.timeout",    64'(timeout_a),    64'(ma.to));
      chk("a.ovr_sticky", 64'(ovr_sticky_a), 64'(ma.ovs[NA-1:0]));
      chk("a.to_sticky",  64'(to_sticky_a),  64'(ma.tos));
      chk("b.ch_count",   64'(ch_count_b),   64'(mb.cnt[NB-1:0]));
      chk("b.set_count",  64'(set_count_b),  64'(mb.setc));
      chk("b.pending",    64'(pending_b),    64'(mb.pend[NB-1:0]));
      chk("b.ready",      64'(ready_b),      64'(mb.rdy));
      chk("b.overrun",    64'(overrun_b),    64'(mb.ovr));
      chk("b.timeout",    64'(timeout_b),    64'(mb.to));
      chk("b.ovr_sticky", 64'(ovr_sticky_b), 64'(mb.ovs[NB-1:0]));
      chk("b.to_sticky",  64'(to_sticky_b),  64'(mb.tos));
   endtask

   // One clock: drive inputs, advance both models on the edge, compare #1 later.
   task automatic cyc(input logic [3:0] ua, input logic [2:0] ub, input bit clr, input bit rst);
      upd_a     = ua;
      upd_b     = ub;
      clear_err = clr;
      resetn    = !rst;
      @(posedge clk);
      ma = step(ma, NA, TA, DA != 0, 8'(ua), clr, rst);
      mb = step(mb, NB, TB, DB != 0, 8'(ub), clr, rst);
      #1;
      check_all();
   endtask

   initial begin
      ma = '0;
      mb = '0;
      // Reset state
      cyc(4'h0, 3'h0, 0, 1);
      cyc(4'h0, 3'h0, 0, 1);
      chk("reset.set_count", 64'(set_count_a), 64'd0);

      // Out-of-order set: ch0, ch2, ch3, ch1
      cyc(4'h1, 3'h1, 0, 0);
      cyc(4'h4, 3'h4, 0, 0);
      cyc(4'h8, 3'h0, 0, 0);
      chk("order.no_ready_early", 64'(ready_a), 64'd0);
      cyc(4'h2, 3'h2, 0, 0);
      chk("order.ready", 64'(ready_a), 64'd1);
      chk("order.set_count", 64'(set_count_a), 64'd1);
      cyc(4'h0, 3'h0, 0, 0);
      chk("order.ready_once", 64'(ready_a), 64'd0);

      // All channels together three cycles in a row
      for (int k = 0; k < 3; k++) begin
         cyc(4'hF, 3'h7, 0, 0);
         chk("burst.ready", 64'(ready_a), 64'd1);
      end
      chk("burst.set_count", 64'(set_count_a), 64'd4);

      // ch0 twice before the set completes
      cyc(4'h1, 3'h1, 0, 0);
      cyc(4'h1, 3'h1, 0, 0);
      chk("ovr.pulse", 64'(overrun_a), 64'd1);
      chk("ovr.sticky", 64'(ovr_sticky_a), 64'h1);
      cyc(4'hE, 3'h6, 0, 0);
      chk("ovr.ready", 64'(ready_a), 64'd1);
      cyc(4'h0, 3'h0, 1, 0);
      chk("clr.sticky", 64'(ovr_sticky_a), 64'h0);

      // Partial set on A times out 10 cycles after the lone ch0 strobe
      cyc(4'h1, 3'h1, 0, 0);
      for (int k = 0; k < 9; k++) cyc(4'h0, 3'h0, 0, 0);
      chk("to.not_yet", 64'(timeout_a), 64'd0);
      cyc(4'h0, 3'h0, 0, 0);
      chk("to.pulse", 64'(timeout_a), 64'd1);
      chk("to.pending", 64'(pending_a), 64'h0);
      chk("to.sticky", 64'(to_sticky_a), 64'd1);
      chk("to.set_count", 64'(set_count_a), 64'd5);
      chk("to.b_keeps_pending", 64'(pending_b), 64'h1);

      // Reset in the middle of a set
      cyc(4'h5, 3'h5, 0, 0);
      chk("mid.pending", 64'(pending_a), 64'h5);
      cyc(4'h0, 3'h0, 0, 1);
      chk("mid.pending_clr", 64'(pending_a), 64'h0);
      chk("mid.ch_count_clr", 64'(ch_count_a), 64'h0);
      chk("mid.to_sticky_clr", 64'(to_sticky_a), 64'd0);
      cyc(4'h0, 3'h0, 0, 0);
      chk("mid.no_ready", 64'(ready_a), 64'd0);

      // Clear and new overrun in the same cycle: overrun wins
      cyc(4'h1, 3'h1, 0, 0);
      cyc(4'h1, 3'h1, 1, 0);
      chk("clr_vs_ovr.sticky", 64'(ovr_sticky_a), 64'h1);

      // Counter wrap: 256 full sets from reset
      cyc(4'h0, 3'h0, 0, 1);
      for (int k = 0; k < 256; k++) cyc(4'hF, 3'h7, 0, 0);
      chk("wrap.set_count", 64'(set_count_a), 64'd0);
      chk("wrap.ch_count", 64'(ch_count_a), 64'h0);
      cyc(4'hF, 3'h7, 0, 0);
      chk("wrap.set_count1", 64'(set_count_a), 64'd1);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         logic [3:0] ra;
         logic [2:0] rb;
         for (int c = 0; c < 4; c++) ra[c] = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < 3; c++) rb[c] = ($urandom_range(0, 4) == 0);
         cyc(ra, rb, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
